// File: rtl/usb_ep_reg_bank.sv
// USB endpoint register bank: decodes front-end register accesses, serialises
// multi-byte buffer transfers into per-byte FIFO strobes, keeps STATUS/ERROR and
// issues TX packet commands. Define USB_REG_BANK_IRQ_EN to add IRQ_MASK and irq.
module usb_ep_reg_bank #(
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 64,
    parameter int OCC_W     = 7,
    localparam int SZ_W     = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req,
    input  logic [3:0]        reg_addr,
    input  logic              reg_write,
    input  logic [SZ_W-1:0]   size,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              hold,
    input  logic [OCC_W-1:0]  buffer_occupancy,
    input  logic [7:0]        rx_data,
    output logic              get_rx_data,
    output logic              store_tx_data,
    output logic [7:0]        tx_data,
    output logic              clear,
    input  logic [2:0]        rx_packet,
    input  logic              rx_data_ready,
    input  logic              rx_transfer_active,
    input  logic              rx_error,
    input  logic              tx_transfer_active,
    input  logic              tx_error,
    output logic [2:0]        tx_packet,
    output logic              tx_start,
    output logic              d_mode
`ifdef USB_REG_BANK_IRQ_EN
    ,
    output logic              irq
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [SZ_W-1:0]   size_q, size_d, idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              done_q, done_d, clear_q, clear_d;
    logic [3:0]        pid_q, pid_d;
    logic [3:0]        err_q, err_d;
    logic [2:0]        txc_q, txc_d;
    logic [15:0]       irq_mask_q, irq_mask_d;
    logic              irq_q, irq_d;

    logic              xfer_s, occ_nz_s, full_s, pop_s, push_s, req_idle_s;
    logic [SZ_W+2:0]   bit_s;
    logic [15:0]       status_s, reg_val_s;

    assign xfer_s     = (state_q == XFER);
    assign occ_nz_s   = (buffer_occupancy != '0);
    assign full_s     = (buffer_occupancy >= OCC_W'(BUF_DEPTH));
    assign pop_s      = xfer_s && !wr_q && occ_nz_s;
    assign push_s     = xfer_s && wr_q && !full_s;
    assign req_idle_s = req && (state_q == IDLE);
    assign bit_s      = {idx_q, 3'b000};
    assign status_s   = {6'b000000, tx_transfer_active, rx_transfer_active, 3'b000, pid_q, occ_nz_s};

    // Byte strobes follow live occupancy so an empty/full FIFO is never touched.
    assign get_rx_data   = pop_s;
    assign store_tx_data = push_s;
    assign tx_data       = push_s ? wdata_q[bit_s +: 8] : 8'h00;
    assign hold          = (state_q != IDLE);
    assign done          = done_q;
    assign rdata         = rdata_q;
    assign clear         = clear_q;
    assign tx_start      = (txc_q != 3'd0) && !tx_transfer_active;
    assign tx_packet     = tx_start ? txc_q : 3'd0;
    assign d_mode        = tx_transfer_active;
`ifdef USB_REG_BANK_IRQ_EN
    assign irq           = irq_q;
`endif

    // Register read multiplexer.
    always_comb begin
        reg_val_s = 16'h0000;
        case (reg_addr)
            4'd1:    reg_val_s = status_s;
            4'd2:    reg_val_s = {12'h000, err_q};
            4'd3:    reg_val_s = 16'(buffer_occupancy);
            4'd4:    reg_val_s = {13'h0000, txc_q};
`ifdef USB_REG_BANK_IRQ_EN
            4'd6:    reg_val_s = irq_mask_q;
`endif
            default: reg_val_s = 16'h0000;
        endcase
    end

    // Next-state logic for the access sequencer and all registers.
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        clear_d    = 1'b0;
        pid_d      = pid_q;
        txc_d      = txc_q;
        irq_mask_d = irq_mask_q;
        irq_d      = 1'b0;

        if (rx_data_ready) begin
            case (rx_packet)
                3'd0:    pid_d = 4'b0000;
                3'd1:    pid_d = 4'b0001;
                3'd2:    pid_d = 4'b0010;
                3'd3:    pid_d = 4'b0100;
                3'd4:    pid_d = 4'b1000;
                default: pid_d = pid_q;
            endcase
        end else begin
            pid_d = pid_q;
        end

        // An ERROR read clears the register, but same-cycle set events survive.
        err_d = ((req_idle_s && !reg_write && (reg_addr == 4'd2)) ? 4'h0 : err_q)
              | {xfer_s && !wr_q && !occ_nz_s, xfer_s && wr_q && full_s, tx_error, rx_error};

        if (tx_start) begin
            txc_d = 3'd0;
        end else begin
            txc_d = txc_q;
        end
        if (req_idle_s && reg_write && (reg_addr == 4'd4)
            && (wdata[7:0] >= 8'd1) && (wdata[7:0] <= 8'd4)) begin
            txc_d = wdata[2:0];
        end else begin
            txc_d = txc_d;
        end

`ifdef USB_REG_BANK_IRQ_EN
        if (req_idle_s && reg_write && (reg_addr == 4'd6)) begin
            irq_mask_d = wdata[15:0];
        end else begin
            irq_mask_d = irq_mask_q;
        end
        irq_d = |({4'h0, err_q, 3'b000, status_s[4:0]} & irq_mask_q);
`endif

        case (state_q)
            IDLE: begin
                if (req && (reg_addr == 4'd0)) begin
                    state_d = XFER;
                    size_d  = size;
                    wr_d    = reg_write;
                    wdata_d = wdata;
                    idx_d   = '0;
                    rdata_d = '0;
                end else if (req) begin
                    done_d  = 1'b1;
                    rdata_d = reg_write ? '0 : DATA_W'(reg_val_s);
                    clear_d = reg_write && (reg_addr == 4'd5) && (wdata != '0);
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (!wr_q) begin
                    rdata_d[bit_s +: 8] = pop_s ? rx_data : 8'h00;
                end else begin
                    rdata_d = rdata_q;
                end
                if (idx_q == size_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + SZ_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            size_q     <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            clear_q    <= 1'b0;
            pid_q      <= 4'h0;
            err_q      <= 4'h0;
            txc_q      <= 3'd0;
            irq_mask_q <= 16'h0000;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            clear_q    <= clear_d;
            pid_q      <= pid_d;
            err_q      <= err_d;
            txc_q      <= txc_d;
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_usb_ep_reg_bank.sv
// Directed self-checking bench for usb_ep_reg_bank (default parameters).
module tb_usb_ep_reg_bank;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  reg_addr = 4'd0;
    logic        reg_write = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        done, hold;
    logic [6:0]  buffer_occupancy = 7'd0;
    logic [7:0]  rx_data = 8'h00;
    logic        get_rx_data, store_tx_data, clear;
    logic [7:0]  tx_data;
    logic [2:0]  rx_packet = 3'd0;
    logic        rx_data_ready = 1'b0, rx_transfer_active = 1'b0, rx_error = 1'b0;
    logic        tx_transfer_active = 1'b0, tx_error = 1'b0;
    logic [2:0]  tx_packet;
    logic        tx_start, d_mode;
`ifdef USB_REG_BANK_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_ep_reg_bank dut (
        .clk(clk), .n_rst(n_rst), .req(req), .reg_addr(reg_addr), .reg_write(reg_write),
        .size(size), .wdata(wdata), .rdata(rdata), .done(done), .hold(hold),
        .buffer_occupancy(buffer_occupancy), .rx_data(rx_data), .get_rx_data(get_rx_data),
        .store_tx_data(store_tx_data), .tx_data(tx_data), .clear(clear),
        .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
        .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
        .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
        .tx_packet(tx_packet), .tx_start(tx_start), .d_mode(d_mode)
`ifdef USB_REG_BANK_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle request; returns in the cycle after req.
    task automatic access(input logic [3:0] a, input logic w, input logic [1:0] sz, input logic [31:0] d);
        req = 1'b1; reg_addr = a; reg_write = w; size = sz; wdata = d;
        step();
        req = 1'b0; reg_addr = 4'd0; reg_write = 1'b0; size = 2'd0; wdata = 32'h0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if ({rdata, done, hold, get_rx_data, store_tx_data, tx_data, clear, tx_packet, tx_start, d_mode} !== 49'h0) begin
            errors++; $display("FAIL reset_outputs: got rdata=%h done=%b hold=%b clear=%b tx_start=%b, expected all 0", rdata, done, hold, clear, tx_start); end
        n_rst = 1'b1;
        step();
        checks++; if (hold !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_release: hold=%b done=%b, expected 0 0", hold, done); end
    endtask

    task automatic test_buf_write();
        logic [7:0] exp_b [4];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        buffer_occupancy = 7'd10;
        access(4'd0, 1'b1, 2'd3, 32'hDDCCBBAA);
        for (int k = 0; k < 4; k++) begin
            checks++; if (hold !== 1'b1 || done !== 1'b0 || clear !== 1'b0) begin
                errors++; $display("FAIL wr_hold_%0d: hold=%b done=%b clear=%b, expected 1 0 0", k, hold, done, clear); end
            checks++; if (store_tx_data !== 1'b1 || tx_data !== exp_b[k]) begin
                errors++; $display("FAIL wr_byte_%0d: store=%b tx_data=%h, expected 1 %h", k, store_tx_data, tx_data, exp_b[k]); end
            if (k == 1) begin
                req = 1'b1; reg_addr = 4'd5; reg_write = 1'b1; wdata = 32'h1;
            end
            step();
            req = 1'b0; reg_addr = 4'd0; reg_write = 1'b0; wdata = 32'h0;
        end
        checks++; if (done !== 1'b1 || hold !== 1'b1 || store_tx_data !== 1'b0) begin
            errors++; $display("FAIL wr_done: done=%b hold=%b store=%b, expected 1 1 0", done, hold, store_tx_data); end
        step();
        checks++; if (done !== 1'b0 || hold !== 1'b0 || clear !== 1'b0) begin
            errors++; $display("FAIL wr_idle: done=%b hold=%b clear=%b, expected 0 0 0", done, hold, clear); end
    endtask

    task automatic test_buf_read();
        buffer_occupancy = 7'd1;
        rx_data = 8'h5A;
        access(4'd0, 1'b0, 2'd1, 32'h0);
        checks++; if (get_rx_data !== 1'b1 || hold !== 1'b1) begin
            errors++; $display("FAIL rd_pop0: get=%b hold=%b, expected 1 1", get_rx_data, hold); end
        step();
        buffer_occupancy = 7'd0;
        #1;
        checks++; if (get_rx_data !== 1'b0 || hold !== 1'b1) begin
            errors++; $display("FAIL rd_pop1_empty: get=%b hold=%b, expected 0 1", get_rx_data, hold); end
        step();
        checks++; if (done !== 1'b1 || rdata !== 32'h0000005A) begin
            errors++; $display("FAIL rd_data: done=%b rdata=%h, expected 1 0000005a", done, rdata); end
        step();
        access(4'd2, 1'b0, 2'd0, 32'h0);
        checks++; if (done !== 1'b1 || hold !== 1'b0 || rdata !== 32'h00000008) begin
            errors++; $display("FAIL err_underflow: done=%b hold=%b rdata=%h, expected 1 0 00000008", done, hold, rdata); end
        access(4'd2, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL err_cleared: rdata=%h, expected 00000000", rdata); end
    endtask

    task automatic test_overflow();
        buffer_occupancy = 7'd64;
        access(4'd0, 1'b1, 2'd0, 32'h00000011);
        checks++; if (store_tx_data !== 1'b0 || hold !== 1'b1) begin
            errors++; $display("FAIL ovf_no_push: store=%b hold=%b, expected 0 1", store_tx_data, hold); end
        step();
        checks++; if (done !== 1'b1) begin
            errors++; $display("FAIL ovf_done: done=%b, expected 1", done); end
        step();
        access(4'd2, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h00000004) begin
            errors++; $display("FAIL err_overflow: rdata=%h, expected 00000004", rdata); end
        buffer_occupancy = 7'd0;
    endtask

    task automatic test_error_set_wins();
        rx_error = 1'b1;
        access(4'd2, 1'b0, 2'd0, 32'h0);
        rx_error = 1'b0;
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL err_coincide_read: rdata=%h, expected 00000000", rdata); end
        access(4'd2, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h00000001) begin
            errors++; $display("FAIL err_set_wins: rdata=%h, expected 00000001", rdata); end
        access(4'd2, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL err_reclear: rdata=%h, expected 00000000", rdata); end
    endtask

    task automatic test_status();
        rx_packet = 3'd1; rx_data_ready = 1'b1;
        step();
        rx_data_ready = 1'b0;
        access(4'd1, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h00000002) begin
            errors++; $display("FAIL status_in: rdata=%h, expected 00000002", rdata); end
        rx_packet = 3'd3; rx_data_ready = 1'b1;
        step();
        rx_data_ready = 1'b0;
        access(4'd1, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h00000008) begin
            errors++; $display("FAIL status_ack: rdata=%h, expected 00000008", rdata); end
        buffer_occupancy = 7'd5; rx_transfer_active = 1'b1;
        access(4'd1, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h00000109) begin
            errors++; $display("FAIL status_live: rdata=%h, expected 00000109", rdata); end
        rx_packet = 3'd0; rx_data_ready = 1'b1;
        step();
        rx_data_ready = 1'b0;
        access(4'd1, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h00000101) begin
            errors++; $display("FAIL status_data_pid: rdata=%h, expected 00000101", rdata); end
        access(4'd3, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h00000005) begin
            errors++; $display("FAIL buf_occ: rdata=%h, expected 00000005", rdata); end
        buffer_occupancy = 7'd0; rx_transfer_active = 1'b0;
    endtask

    task automatic test_tx_ctrl();
        tx_transfer_active = 1'b1;
        #1;
        checks++; if (d_mode !== 1'b1) begin
            errors++; $display("FAIL d_mode_hi: d_mode=%b, expected 1", d_mode); end
        access(4'd4, 1'b1, 2'd0, 32'h2);
        for (int i = 0; i < 5; i++) begin
            checks++; if (tx_start !== 1'b0 || tx_packet !== 3'd0) begin
                errors++; $display("FAIL tx_wait_%0d: tx_start=%b tx_packet=%0d, expected 0 0", i, tx_start, tx_packet); end
            step();
        end
        tx_transfer_active = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b1 || tx_packet !== 3'd2 || d_mode !== 1'b0) begin
            errors++; $display("FAIL tx_issue: tx_start=%b tx_packet=%0d d_mode=%b, expected 1 2 0", tx_start, tx_packet, d_mode); end
        step();
        checks++; if (tx_start !== 1'b0 || tx_packet !== 3'd0) begin
            errors++; $display("FAIL tx_one_shot: tx_start=%b tx_packet=%0d, expected 0 0", tx_start, tx_packet); end
        access(4'd4, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL tx_ctrl_cleared: rdata=%h, expected 00000000", rdata); end
        tx_transfer_active = 1'b1;
        access(4'd4, 1'b1, 2'd0, 32'h5);
        access(4'd4, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL tx_ctrl_bad_code: rdata=%h, expected 00000000", rdata); end
        tx_transfer_active = 1'b0;
        access(4'd4, 1'b1, 2'd0, 32'h1);
        checks++; if (tx_start !== 1'b1 || tx_packet !== 3'd1) begin
            errors++; $display("FAIL tx_zlp: tx_start=%b tx_packet=%0d, expected 1 1", tx_start, tx_packet); end
        step();
    endtask

    task automatic test_flush();
        access(4'd5, 1'b1, 2'd0, 32'h1);
        checks++; if (clear !== 1'b1 || done !== 1'b1) begin
            errors++; $display("FAIL flush_pulse: clear=%b done=%b, expected 1 1", clear, done); end
        step();
        checks++; if (clear !== 1'b0) begin
            errors++; $display("FAIL flush_one_cycle: clear=%b, expected 0", clear); end
        access(4'd5, 1'b1, 2'd0, 32'h0);
        checks++; if (clear !== 1'b0) begin
            errors++; $display("FAIL flush_zero: clear=%b, expected 0", clear); end
        access(4'd5, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL flush_read: rdata=%h, expected 00000000", rdata); end
    endtask

    task automatic test_opt_irq();
`ifdef USB_REG_BANK_IRQ_EN
        access(4'd6, 1'b1, 2'd0, 32'h0100);
        tx_error = 1'b1;
        step();
        tx_error = 1'b0;
        step();
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_masked: irq=%b, expected 0", irq); end
        access(4'd6, 1'b1, 2'd0, 32'h0200);
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_latency: irq=%b, expected 0", irq); end
        step();
        checks++; if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_set: irq=%b, expected 1", irq); end
        access(4'd2, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h00000002) begin
            errors++; $display("FAIL irq_err: rdata=%h, expected 00000002", rdata); end
`else
        access(4'd6, 1'b1, 2'd0, 32'hFFFF);
        access(4'd6, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h0) begin
            errors++; $display("FAIL addr6_reads_zero: rdata=%h, expected 00000000", rdata); end
`endif
    endtask

    task automatic test_reset_mid_xfer();
        buffer_occupancy = 7'd10;
        access(4'd1, 1'b0, 2'd0, 32'h0);
        checks++; if (rdata !== 32'h00000001) begin
            errors++; $display("FAIL pre_reset_status: rdata=%h, expected 00000001", rdata); end
        step();
        access(4'd0, 1'b1, 2'd3, 32'hDDCCBBAA);
        step();
        n_rst = 1'b0;
        #1;
        checks++; if ({rdata, done, hold, store_tx_data, tx_data, clear} !== 44'h0) begin
            errors++; $display("FAIL reset_abort: rdata=%h done=%b hold=%b store=%b tx_data=%h, expected all 0", rdata, done, hold, store_tx_data, tx_data); end
        step();
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (done !== 1'b0 || hold !== 1'b0) begin
                errors++; $display("FAIL no_done_after_reset_%0d: done=%b hold=%b, expected 0 0", i, done, hold); end
            step();
        end
        buffer_occupancy = 7'd0;
    endtask

    initial begin
        test_reset();
        test_buf_write();
        test_buf_read();
        test_overflow();
        test_error_set_wins();
        test_status();
        test_tx_ctrl();
        test_flush();
        test_opt_irq();
        test_reset_mid_xfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/usb_ep_reg_bank.md
Name: usb_ep_reg_bank

Overview:
- Parametrised register bank and data-buffer access sequencer for the USB endpoint's AHB-lite slave.
- Decodes register accesses already captured by the bus front-end and serialises multi-byte buffer reads and writes into per-byte FIFO strobes, stalling the bus with hold.
- Keeps sticky status and error registers and issues TX packet commands to the USB transmitter.
- Sits between the AHB-lite slave front-end and the rx/tx FIFO and USB TX/RX engines.

Parameters:
- DATA_W, 32, bus data width in bits; multiple of 8, range 8..64.
- BUF_DEPTH, 64, FIFO capacity in bytes.
- OCC_W, 7, width of buffer_occupancy; must satisfy 2^OCC_W > BUF_DEPTH.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset; asynchronous, active-low
- req  in  1  one-cycle access request from the bus front-end
- reg_addr  in  4  register address
- reg_write  in  1  1=write, 0=read; sampled with req
- size  in  $clog2(DATA_W/8)  bytes-1 for buffer accesses; sampled with req
- wdata  in  DATA_W  write data; sampled with req
- rdata  out  DATA_W  read data; valid when done=1
- done  out  1  access-complete pulse
- hold  out  1  access in progress; front-end must stall
- buffer_occupancy  in  OCC_W  FIFO byte count
- rx_data  in  8  FIFO head byte
- get_rx_data  out  1  FIFO pop strobe
- store_tx_data  out  1  FIFO push strobe
- tx_data  out  8  push byte
- clear  out  1  FIFO flush pulse
- rx_packet  in  3  decoded PID: 0 DATA, 1 IN, 2 OUT, 3 ACK, 4 NAK
- rx_data_ready, rx_transfer_active, rx_error  in  1 each  RX engine status
- tx_transfer_active, tx_error  in  1 each  TX engine status
- tx_packet  out  3  0 none, 1 DATA, 2 ACK, 3 NAK, 4 STALL
- tx_start  out  1  one-cycle transmit command
- d_mode  out  1  equals tx_transfer_active (combinational)

Behaviour:
- Reset values: all outputs 0; all registers 0; FSM in IDLE.
- Address map:
  - 0 DATA buffer
  - 1 STATUS[15:0]
  - 2 ERROR[15:0]
  - 3 BUF_OCC
  - 4 TX_CTRL[7:0]
  - 5 FLUSH
  - others: read 0, write ignored.
- Non-buffer access:
  - done=1 the cycle after req.
  - rdata holds the zero-extended register value for that cycle; hold stays 0.
- Buffer access FSM (IDLE -> XFER -> DONE -> IDLE):
  - req with addr 0 enters XFER and latches size, reg_write and wdata; byte index k counts 0..size.
  - hold=1 throughout XFER and DONE.
  - Each XFER cycle handles one byte, LSB first.
  - Write: store_tx_data=1 and tx_data=wdata[8k+7:8k].
  - Read: get_rx_data=1 and rx_data is captured into rdata[8k+7:8k].
  - DONE lasts one cycle with done=1; unread upper bytes of rdata are 0.
  - Total latency is size+2 cycles after req.
- Boundaries, evaluated each XFER cycle against the current buffer_occupancy:
  - Read with occupancy 0: no pop, byte reads 0x00, ERROR[3] (underflow) set.
  - Write with occupancy >= BUF_DEPTH: no push, ERROR[2] (overflow) set.
  - The transfer still completes normally in both cases.
  - A req arriving while hold=1 is ignored.
- STATUS:
  - [0] = occupancy > 0, live.
  - [1..4] = IN/OUT/ACK/NAK. On an rx_data_ready pulse, the bit matching rx_packet is set and the other three are cleared; a DATA PID clears all four.
  - [8] = rx_transfer_active, [9] = tx_transfer_active, live.
- ERROR bits are sticky:
  - [0] rx_error, [1] tx_error, [2] overflow, [3] underflow.
  - The whole register clears when an ERROR read completes.
  - If a set event coincides with the read cycle, the set wins.
- TX_CTRL:
  - Writing 1..4 loads a pending command; a write of 0 or >4 is ignored.
  - While pending and tx_transfer_active=0, issue tx_start=1 with tx_packet=code for one cycle, then clear TX_CTRL to 0.
  - A new write while pending overwrites the command.
  - A DATA command with occupancy 0 is still sent (zero-length packet).
- FLUSH: a write of any nonzero value pulses clear=1 for one cycle, the cycle after req. FLUSH reads 0.
- Reset asserted mid-transfer aborts immediately; no partial done is produced.

Optional Feature:
- Macro USB_REG_BANK_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) and register 6 IRQ_MASK[15:0], reset 0.
  - irq is registered: (STATUS[4:0] | ERROR[3:0]<<8) & IRQ_MASK, OR-reduced, with one cycle latency.
- When undefined: no irq port; address 6 reads 0 and writes are ignored.

Test Plan:
- Write DATA, size=3, wdata=0xDDCCBBAA, occupancy=10 -> store_tx_data for 4 consecutive cycles with tx_data AA, BB, CC, DD; hold=1 for 5 cycles; done at cycle 5.
- Read DATA, size=1, occupancy=1, rx_data=0x5A -> one pop; rdata=0x0000005A; ERROR[3]=1; a following ERROR read returns 0x0008, then ERROR reads 0.
- rx_data_ready with rx_packet=1, then with rx_packet=3 -> STATUS[1]=1, then STATUS[1]=0 and STATUS[3]=1.
- Write TX_CTRL=2 while tx_transfer_active=1 for 5 cycles -> no tx_start; tx_start=1 and tx_packet=2 on the first inactive cycle; TX_CTRL then reads 0.
- Write FLUSH=1 -> clear=1 exactly one cycle, the cycle after req; n_rst pulsed during XFER -> all outputs 0 and no done.
- With IRQ_EN: IRQ_MASK=0x0100, assert tx_error -> ERROR[1]=1, irq stays 0; IRQ_MASK=0x0200 -> irq=1 one cycle later.
